audio_flt_cfg_seq: RTL
======================

Name: audio_flt_cfg_seq

Overview:
- Configuration sequencer for the audio output filter datapath.
- A host writes filter-rate and IIR coefficient words into a shadow bank. A commit pulse then runs a glitch-free update: ramp the output gain down, copy shadow to active atomically, wait for the filter to settle, ramp the gain back up.
- Sits between the host register interface and the audio output/IIR block. Drives flt_rate, cx*, cy* and a gain word applied after the DC blocker.

Parameters:
- RAMP_STEP, 1, gain increment/decrement per audio_clk strobe (1..255).
- SETTLE_SAMPLES, 480, audio_clk strobes to wait after load before ramp-up (1..65535).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- audio_clk  in  1  one-cycle sample strobe in the clk domain
- cfg_we  in  1  shadow write enable
- cfg_addr  in  4  shadow word address
- cfg_data  in  16  shadow write data
- commit  in  1  one-cycle request to apply the shadow bank
- flt_rate  out  32  active filter rate
- cx  out  40  active input gain
- cx0, cx1, cx2  out  8 each  active feed-forward coefficients
- cy0, cy1, cy2  out  24 each  active feedback coefficients
- gain  out  8  output gain, 255 = unity
- busy  out  1  high whenever state != IDLE

Behaviour:
- Shadow map (16-bit words; an upper byte beyond the field width is ignored):
  - 0/1 = flt_rate[15:0]/[31:16]
  - 2/3/4 = cx[15:0]/[31:16]/[39:32]
  - 5/6/7 = cx0/cx1/cx2
  - 8/9 = cy0[15:0]/[23:16]
  - 10/11 = cy1
  - 12/13 = cy2
  - Addresses 14, 15: writes ignored.
- Shadow writes are accepted in every state, one clock, no backpressure.
- Reset: shadow and all active outputs = 0; gain = 0; state = IDLE; pending = 0; settle counter = 0.
- FSM states: IDLE, RAMP_DN, LOAD, SETTLE, RAMP_UP.
  - IDLE: commit -> RAMP_DN on the next clock.
  - RAMP_DN:
    - If gain == 0 -> LOAD.
    - Otherwise, on each audio_clk: gain <= (gain > RAMP_STEP) ? gain - RAMP_STEP : 0.
    - A commit here has no effect.
  - LOAD (exactly one clock):
    - active <= shadow, visible from the next clock.
    - A shadow write in the same cycle is NOT captured; it lands in the shadow only.
    - Clears the settle counter. -> SETTLE.
  - SETTLE:
    - Counter increments on each audio_clk.
    - When the counter reaches SETTLE_SAMPLES -> RAMP_UP.
    - gain held at 0.
  - RAMP_UP:
    - On each audio_clk: gain <= min(gain + RAMP_STEP, 255), computed 9-bit then saturated.
    - When gain == 255 -> IDLE.
- Commit while in LOAD, SETTLE or RAMP_UP sets pending.
  - In SETTLE or RAMP_UP with pending = 1: abort to RAMP_DN next clock and clear pending.
  - The ramp-down continues from the current gain.
- If commit and the abort condition occur in the same cycle, the net effect is one RAMP_DN entry.
- The active outputs change only in the LOAD cycle; they never change while gain != 0.
- audio_clk coinciding with a state-entry cycle is consumed by the new state only if the state register already holds it; strobes are not queued.
- Reset asserted mid-sequence returns everything to reset values immediately. Shadow contents are lost.
- After reset the first commit takes RAMP_DN for 1 clock (gain already 0), then LOAD.
- Latency from commit to the active outputs updating:
  - 3 clocks when gain = 0.
  - Otherwise 2 clocks plus the ramp-down duration.

Test Plan (RAMP_STEP=16, SETTLE_SAMPLES=4, audio_clk every 8 clocks):
- Reset, write words 0..13 with 0x1111*(addr+1), commit at cycle t -> busy=1 from t+1; active outputs change at t+3 (flt_rate=0x22221111, cx=0x5544443333, cy0=0xAA9999); gain 0 through 4 strobes; gain rises 16, 32, ... 240, 255 over 16 strobes; then busy=0.
- From IDLE with gain=255, commit -> gain steps 239, 223, ... 15, 0 (16 strobes); active outputs do not change before gain=0; LOAD follows the cycle after gain hits 0.
- Write addresses 14 and 15 plus upper bytes of addresses 4–7 and 9, commit -> no output change beyond the mapped bits (cx0 takes only data[7:0]).
- Commit during RAMP_UP at gain=128 -> next clock state RAMP_DN, gain descends from 128 by 16; the new shadow values load once gain reaches 0.
- Shadow write coincident with LOAD -> old value appears on the active outputs; the new value is applied only by a subsequent commit.
- Assert reset during SETTLE -> all outputs 0 and busy=0 on assertion; a post-reset commit completes a full sequence.

Source files
------------

// File: rtl/audio_flt_cfg_seq.sv
// ---------------------------------------------------------------------------
// audio_flt_cfg_seq
// Configuration sequencer for the audio output filter. The host fills a
// shadow bank of filter-rate / IIR coefficient words; a commit pulse ramps
// the output gain to zero, copies shadow to active in a single clock, waits
// for the filter to settle and ramps the gain back to unity.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high
//   audio_clk  one-cycle sample strobe (clk domain); paces ramps and settle
//   cfg_we     shadow write enable
//   cfg_addr   shadow word address (0..13 mapped, 14/15 ignored)
//   cfg_data   shadow write data (upper byte dropped on narrow fields)
//   commit     one-cycle request to apply the shadow bank
//   flt_rate   active filter rate
//   cx         active input gain
//   cx0..cx2   active feed-forward coefficients
//   cy0..cy2   active feedback coefficients
//   gain       output gain, 255 = unity
//   busy       high whenever the sequencer is not idle
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | gain static, waiting for commit
// RAMP_DN | gain stepping down on audio_clk until it reaches 0
// LOAD    | one clock: active <= shadow, settle counter cleared
// SETTLE  | gain held at 0 for SETTLE_SAMPLES strobes
// RAMP_UP | gain stepping up on audio_clk until it saturates at 255
// ---------------------------------------------------------------------------
module audio_flt_cfg_seq #(
   parameter int RAMP_STEP      = 1,
   parameter int SETTLE_SAMPLES = 480
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        audio_clk,
   input  logic        cfg_we,
   input  logic [3:0]  cfg_addr,
   input  logic [15:0] cfg_data,
   input  logic        commit,
   output logic [31:0] flt_rate,
   output logic [39:0] cx,
   output logic [7:0]  cx0,
   output logic [7:0]  cx1,
   output logic [7:0]  cx2,
   output logic [23:0] cy0,
   output logic [23:0] cy1,
   output logic [23:0] cy2,
   output logic [7:0]  gain,
   output logic        busy
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] RAMP_DN = 3'd1;
   localparam logic [2:0] LOAD    = 3'd2;
   localparam logic [2:0] SETTLE  = 3'd3;
   localparam logic [2:0] RAMP_UP = 3'd4;

   localparam logic [7:0]  STEP8     = 8'(RAMP_STEP);
   localparam logic [15:0] SETTLE_TC = 16'(SETTLE_SAMPLES);

   logic [2:0]  state;
   logic [15:0] settle_cnt;
   logic        pending;

   logic [31:0] sh_rate;
   logic [39:0] sh_cx;
   logic [7:0]  sh_cx0, sh_cx1, sh_cx2;
   logic [23:0] sh_cy0, sh_cy1, sh_cy2;

   logic [7:0]  gain_dn;
   logic [8:0]  gain_sum;
   logic [7:0]  gain_up;
   logic        abort;

   // ---------------------------------------------------------------------
   // Shadow bank: written in any state. A write in the LOAD cycle lands
   // here only, because the active copy samples the pre-edge shadow value.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_rate <= '0;
         sh_cx   <= '0;
         sh_cx0  <= '0;
         sh_cx1  <= '0;
         sh_cx2  <= '0;
         sh_cy0  <= '0;
         sh_cy1  <= '0;
         sh_cy2  <= '0;
      end else if (cfg_we) begin
         case (cfg_addr)
            4'd0:  sh_rate[15:0]  <= cfg_data;
            4'd1:  sh_rate[31:16] <= cfg_data;
            4'd2:  sh_cx[15:0]    <= cfg_data;
            4'd3:  sh_cx[31:16]   <= cfg_data;
            4'd4:  sh_cx[39:32]   <= cfg_data[7:0];
            4'd5:  sh_cx0         <= cfg_data[7:0];
            4'd6:  sh_cx1         <= cfg_data[7:0];
            4'd7:  sh_cx2         <= cfg_data[7:0];
            4'd8:  sh_cy0[15:0]   <= cfg_data;
            4'd9:  sh_cy0[23:16]  <= cfg_data[7:0];
            4'd10: sh_cy1[15:0]   <= cfg_data;
            4'd11: sh_cy1[23:16]  <= cfg_data[7:0];
            4'd12: sh_cy2[15:0]   <= cfg_data;
            4'd13: sh_cy2[23:16]  <= cfg_data[7:0];
            default: ;
         endcase
      end
   end

   // Ramp arithmetic: down clamps at 0, up is formed 9-bit and saturated.
   assign gain_dn  = (gain > STEP8) ? (gain - STEP8) : 8'd0;
   assign gain_sum = {1'b0, gain} + {1'b0, STEP8};
   assign gain_up  = gain_sum[8] ? 8'hFF : gain_sum[7:0];

   // A commit arriving together with a latched one still gives a single
   // return to RAMP_DN; both are consumed by the same transition.
   assign abort = pending | commit;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         gain       <= '0;
         settle_cnt <= '0;
         pending    <= 1'b0;
         flt_rate   <= '0;
         cx         <= '0;
         cx0        <= '0;
         cx1        <= '0;
         cx2        <= '0;
         cy0        <= '0;
         cy1        <= '0;
         cy2        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (commit) state <= RAMP_DN;
            end
            RAMP_DN: begin
               if (gain == 8'd0)   state <= LOAD;
               else if (audio_clk) gain  <= gain_dn;
            end
            LOAD: begin
               flt_rate   <= sh_rate;
               cx         <= sh_cx;
               cx0        <= sh_cx0;
               cx1        <= sh_cx1;
               cx2        <= sh_cx2;
               cy0        <= sh_cy0;
               cy1        <= sh_cy1;
               cy2        <= sh_cy2;
               settle_cnt <= '0;
               if (commit) pending <= 1'b1;
               state      <= SETTLE;
            end
            SETTLE: begin
               if (abort) begin
                  state   <= RAMP_DN;
                  pending <= 1'b0;
               end else if (settle_cnt == SETTLE_TC) begin
                  state <= RAMP_UP;
               end else if (audio_clk) begin
                  settle_cnt <= settle_cnt + 16'd1;
               end
            end
            RAMP_UP: begin
               if (abort) begin
                  state   <= RAMP_DN;
                  pending <= 1'b0;
               end else if (gain == 8'hFF) begin
                  state <= IDLE;
               end else if (audio_clk) begin
                  gain <= gain_up;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule
